reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//  Circular in-order reorder buffer between decode/issue and the register file.
//  Allocates one ROB id per issued instruction and captures results from the ALU and load CDBs.
//  Retires the head entry in order, driving the register-file commit bus.
//  Answers the register file's two operand-lookup queries and triggers the mispredict flush.
// PARAMETERS
//  ROB_SIZE    16  number of entries; power of two
//  ROB_ADDR_W  4   log2(ROB_SIZE)
// PORTS
//  clk               in   1   system clock
//  rst               in   1   synchronous, active-high reset
//  rdy               in   1   global enable; low = freeze all state
//  id_alloc_flag     in   1   issue requests a new entry this cycle
//  id_rd             in   5   destination register (0 = none)
//  id_is_branch      in   1   entry is a conditional branch or jalr
//  id_pred_taken     in   1   predictor decision for the branch
//  rob_full          out  1   no free entry; issue must stall
//  rob_next_id       out  32  id the next allocation receives (index+1)
//  rob_id1, rob_id2  in   32  lookup ids from the register file
//  rob_id1_rdy/2_rdy out  1   looked-up entry is valid and its result is ready
//  rob_id1_val/2_val out  32  result of the looked-up entry
//  ex_cdb_flag       in   1   ALU result broadcast
//  ex_cdb_rob_id     in   32  ALU result owner
//  ex_cdb_val        in   32  ALU result / link value
//  ex_cdb_jump       in   1   actual branch outcome
//  ex_cdb_jump_pc    in   32  correct next pc for the branch
//  ld_cdb_flag       in   1   load result broadcast
//  ld_cdb_rob_id     in   32  load result owner
//  ld_cdb_val        in   32  load result
//  ROB_cmt_flag      out  1   commit pulse to the register file
//  ROB_cmt_rd        out  5   committed destination register
//  ROB_cmt_rob_id    out  32  committed id
//  ROB_cmt_val       out  32  committed value
//  jump_wrong_stall  out  1   one-cycle flush pulse to every stage
//  jump_wrong_pc     out  32  fetch restart pc; valid while jump_wrong_stall=1
// BEHAVIOUR
//  Reset: head=tail=count=0, all entries invalid; every output 0 except rob_next_id=1.
//  rdy=0: no state or registered-output change; lookups stay combinational.
//  Ids: entry index i carries id i+1; id 0 never matches.
//  Allocation: when id_alloc_flag && !rob_full && !flush_pending, write the entry at tail
//   (valid=1, ready=0, rd, branch, pred), then tail wraps ROB_SIZE-1 -> 0.
//   A request with rob_full=1 is dropped silently.
//  rob_full = (count==ROB_SIZE), combinational.
//  Writeback: a CDB flag whose id matches a valid entry sets ready=1 and val.
//   For ex_cdb it also captures jump and jump_pc. Both CDBs may write in the same cycle.
//  Commit: when the head entry is valid && ready && !flush_pending:
//   - Next cycle, ROB_cmt_* carries {rd,id,val} with ROB_cmt_flag=1 (registered, one cycle).
//   - head advances and the entry is invalidated.
//  Commit rate and timing:
//   - At most one commit per cycle.
//   - A writeback to the head becomes committable the following cycle.
//  Alloc and commit in the same cycle leave count unchanged.
//  Mispredict: a committing head with branch=1 and jump!=pred commits normally in cycle N,
//   and sets flush_pending.
//   - Cycle N+1: jump_wrong_stall=1, jump_wrong_pc=jump_pc, ROB_cmt_flag=0;
//     all entries invalid, head=tail=count=0. Allocations in N and N+1 are discarded.
//   - Cycle N+2: normal operation; rob_next_id=1.
//  Lookup (combinational): rob_idK_rdy = valid[id-1] && ready[id-1]; rob_idK_val = val[id-1].
//   Id 0 or out-of-range ids give rdy=0.
//  rst mid-operation overrides flush, commit, and alloc in that cycle.
// TESTING
//  reset -> rob_full=0, rob_next_id=1, ROB_cmt_flag=0, jump_wrong_stall=0
//  alloc rd=5; ex_cdb id=1 val=0x2A -> next cycle ROB_cmt_flag=1, rd=5, id=1, val=0x2A
//  16 allocs, no writeback -> rob_full=1; 17th alloc dropped; ld_cdb id=1 ->
//   commit of id 1, then rob_full=0 and the next alloc gets id 1 (wrap)
//  alloc ids 1,2; cdb id=2 first, then id=1 -> commits id1 then id2 on consecutive cycles
//  branch id=1 pred=0, ex_cdb jump=1 pc=0x100 -> cmt id1, then jump_wrong_stall=1 with
//   pc=0x100, then rob_next_id=1 and count=0
//  lookup id=3 while ready with val=7 -> rob_id1_rdy=1, val=7; rdy=0 for 3 cycles -> no commit

Source files
------------

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: allocates ROB ids at issue, captures ALU/load results,
// retires the head onto the register-file commit bus and raises the mispredict flush.
module reorder_buffer #(
    parameter int ROB_SIZE   = 16,
    parameter int ROB_ADDR_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        id_alloc_flag,
    input  logic [4:0]  id_rd,
    input  logic        id_is_branch,
    input  logic        id_pred_taken,
    output logic        rob_full,
    output logic [31:0] rob_next_id,
    input  logic [31:0] rob_id1,
    input  logic [31:0] rob_id2,
    output logic        rob_id1_rdy,
    output logic        rob_id2_rdy,
    output logic [31:0] rob_id1_val,
    output logic [31:0] rob_id2_val,
    input  logic        ex_cdb_flag,
    input  logic [31:0] ex_cdb_rob_id,
    input  logic [31:0] ex_cdb_val,
    input  logic        ex_cdb_jump,
    input  logic [31:0] ex_cdb_jump_pc,
    input  logic        ld_cdb_flag,
    input  logic [31:0] ld_cdb_rob_id,
    input  logic [31:0] ld_cdb_val,
    output logic        ROB_cmt_flag,
    output logic [4:0]  ROB_cmt_rd,
    output logic [31:0] ROB_cmt_rob_id,
    output logic [31:0] ROB_cmt_val,
    output logic        jump_wrong_stall,
    output logic [31:0] jump_wrong_pc
);

    localparam logic [ROB_ADDR_W:0]   FULL_COUNT = (ROB_ADDR_W+1)'(ROB_SIZE);
    localparam logic [ROB_ADDR_W:0]   CNT_ONE    = (ROB_ADDR_W+1)'(1);
    localparam logic [ROB_ADDR_W-1:0] ADDR_ONE   = ROB_ADDR_W'(1);

    logic [ROB_SIZE-1:0]   valid_r;
    logic [ROB_SIZE-1:0]   ready_r;
    logic [ROB_SIZE-1:0]   branch_r;
    logic [ROB_SIZE-1:0]   pred_r;
    logic [ROB_SIZE-1:0]   jump_r;
    logic [4:0]            rd_r      [ROB_SIZE];
    logic [31:0]           val_r     [ROB_SIZE];
    logic [31:0]           jump_pc_r [ROB_SIZE];
    logic [ROB_ADDR_W-1:0] head_r;
    logic [ROB_ADDR_W-1:0] tail_r;
    logic [ROB_ADDR_W:0]   count_r;
    logic                  flush_pending_r;
    logic [31:0]           flush_pc_r;

    logic                  alloc_s;
    logic                  commit_s;
    logic                  mispredict_s;
    logic                  ex_hit_s;
    logic                  ld_hit_s;
    logic [ROB_ADDR_W-1:0] ex_idx_s;
    logic [ROB_ADDR_W-1:0] ld_idx_s;
    logic [ROB_ADDR_W-1:0] lk1_idx_s;
    logic [ROB_ADDR_W-1:0] lk2_idx_s;

    // Id 0 is reserved for "no producer"; index i carries id i+1.
    function automatic logic id_in_range(input logic [31:0] id);
        return (id != 32'd0) && (id <= 32'(ROB_SIZE));
    endfunction

    function automatic logic [ROB_ADDR_W-1:0] id_to_idx(input logic [31:0] id);
        return ROB_ADDR_W'(id - 32'd1);
    endfunction

    assign ex_idx_s  = id_to_idx(ex_cdb_rob_id);
    assign ld_idx_s  = id_to_idx(ld_cdb_rob_id);
    assign lk1_idx_s = id_to_idx(rob_id1);
    assign lk2_idx_s = id_to_idx(rob_id2);
    assign ex_hit_s  = ex_cdb_flag && id_in_range(ex_cdb_rob_id) && valid_r[ex_idx_s];
    assign ld_hit_s  = ld_cdb_flag && id_in_range(ld_cdb_rob_id) && valid_r[ld_idx_s];

    assign rob_full    = (count_r == FULL_COUNT);
    assign rob_next_id = 32'(tail_r) + 32'd1;

    // Issue is wrong-path while a flush is pending or being broadcast, so it is not accepted.
    assign alloc_s      = id_alloc_flag && !rob_full && !flush_pending_r && !jump_wrong_stall;
    assign commit_s     = valid_r[head_r] && ready_r[head_r] && !flush_pending_r;
    assign mispredict_s = commit_s && branch_r[head_r] && (jump_r[head_r] != pred_r[head_r]);

    assign rob_id1_rdy = id_in_range(rob_id1) && valid_r[lk1_idx_s] && ready_r[lk1_idx_s];
    assign rob_id2_rdy = id_in_range(rob_id2) && valid_r[lk2_idx_s] && ready_r[lk2_idx_s];
    assign rob_id1_val = id_in_range(rob_id1) ? val_r[lk1_idx_s] : 32'd0;
    assign rob_id2_val = id_in_range(rob_id2) ? val_r[lk2_idx_s] : 32'd0;

    // Entry payload: issue fields at allocation, results and branch outcome at writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                rd_r[i]      <= 5'd0;
                val_r[i]     <= 32'd0;
                jump_pc_r[i] <= 32'd0;
            end
            branch_r <= '0;
            pred_r   <= '0;
            jump_r   <= '0;
        end else if (rdy) begin
            if (alloc_s) begin
                rd_r[tail_r]     <= id_rd;
                branch_r[tail_r] <= id_is_branch;
                pred_r[tail_r]   <= id_pred_taken;
                jump_r[tail_r]   <= 1'b0;
            end
            if (ex_hit_s) begin
                val_r[ex_idx_s]     <= ex_cdb_val;
                jump_r[ex_idx_s]    <= ex_cdb_jump;
                jump_pc_r[ex_idx_s] <= ex_cdb_jump_pc;
            end
            if (ld_hit_s) begin
                val_r[ld_idx_s] <= ld_cdb_val;
            end
        end
    end

    // Control state, commit bus and flush broadcast.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r          <= '0;
            ready_r          <= '0;
            head_r           <= '0;
            tail_r           <= '0;
            count_r          <= '0;
            flush_pending_r  <= 1'b0;
            flush_pc_r       <= 32'd0;
            ROB_cmt_flag     <= 1'b0;
            ROB_cmt_rd       <= 5'd0;
            ROB_cmt_rob_id   <= 32'd0;
            ROB_cmt_val      <= 32'd0;
            jump_wrong_stall <= 1'b0;
            jump_wrong_pc    <= 32'd0;
        end else if (rdy) begin
            if (flush_pending_r) begin
                valid_r          <= '0;
                ready_r          <= '0;
                head_r           <= '0;
                tail_r           <= '0;
                count_r          <= '0;
                flush_pending_r  <= 1'b0;
                ROB_cmt_flag     <= 1'b0;
                jump_wrong_stall <= 1'b1;
                jump_wrong_pc    <= flush_pc_r;
            end else begin
                jump_wrong_stall <= 1'b0;
                if (ex_hit_s) begin
                    ready_r[ex_idx_s] <= 1'b1;
                end
                if (ld_hit_s) begin
                    ready_r[ld_idx_s] <= 1'b1;
                end
                if (alloc_s) begin
                    valid_r[tail_r] <= 1'b1;
                    ready_r[tail_r] <= 1'b0;
                    tail_r          <= tail_r + ADDR_ONE;
                end
                ROB_cmt_flag <= commit_s;
                if (commit_s) begin
                    ROB_cmt_rd      <= rd_r[head_r];
                    ROB_cmt_rob_id  <= 32'(head_r) + 32'd1;
                    ROB_cmt_val     <= val_r[head_r];
                    valid_r[head_r] <= 1'b0;
                    head_r          <= head_r + ADDR_ONE;
                end
                if (mispredict_s) begin
                    flush_pending_r <= 1'b1;
                    flush_pc_r      <= jump_pc_r[head_r];
                end
                case ({alloc_s, commit_s})
                    2'b10:   count_r <= count_r + CNT_ONE;
                    2'b01:   count_r <= count_r - CNT_ONE;
                    default: count_r <= count_r;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer: commit path, full/wrap,
// out-of-order writeback, mispredict flush, lookups and the rdy freeze.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        id_alloc_flag;
    logic [4:0]  id_rd;
    logic        id_is_branch;
    logic        id_pred_taken;
    logic        rob_full;
    logic [31:0] rob_next_id;
    logic [31:0] rob_id1;
    logic [31:0] rob_id2;
    logic        rob_id1_rdy;
    logic        rob_id2_rdy;
    logic [31:0] rob_id1_val;
    logic [31:0] rob_id2_val;
    logic        ex_cdb_flag;
    logic [31:0] ex_cdb_rob_id;
    logic [31:0] ex_cdb_val;
    logic        ex_cdb_jump;
    logic [31:0] ex_cdb_jump_pc;
    logic        ld_cdb_flag;
    logic [31:0] ld_cdb_rob_id;
    logic [31:0] ld_cdb_val;
    logic        ROB_cmt_flag;
    logic [4:0]  ROB_cmt_rd;
    logic [31:0] ROB_cmt_rob_id;
    logic [31:0] ROB_cmt_val;
    logic        jump_wrong_stall;
    logic [31:0] jump_wrong_pc;

    int n_checks = 0;
    int n_fail   = 0;

    reorder_buffer dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .id_alloc_flag(id_alloc_flag), .id_rd(id_rd),
        .id_is_branch(id_is_branch), .id_pred_taken(id_pred_taken),
        .rob_full(rob_full), .rob_next_id(rob_next_id),
        .rob_id1(rob_id1), .rob_id2(rob_id2),
        .rob_id1_rdy(rob_id1_rdy), .rob_id2_rdy(rob_id2_rdy),
        .rob_id1_val(rob_id1_val), .rob_id2_val(rob_id2_val),
        .ex_cdb_flag(ex_cdb_flag), .ex_cdb_rob_id(ex_cdb_rob_id),
        .ex_cdb_val(ex_cdb_val), .ex_cdb_jump(ex_cdb_jump),
        .ex_cdb_jump_pc(ex_cdb_jump_pc),
        .ld_cdb_flag(ld_cdb_flag), .ld_cdb_rob_id(ld_cdb_rob_id),
        .ld_cdb_val(ld_cdb_val),
        .ROB_cmt_flag(ROB_cmt_flag), .ROB_cmt_rd(ROB_cmt_rd),
        .ROB_cmt_rob_id(ROB_cmt_rob_id), .ROB_cmt_val(ROB_cmt_val),
        .jump_wrong_stall(jump_wrong_stall), .jump_wrong_pc(jump_wrong_pc)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_alloc_flag = 1'b0; id_rd = 5'd0; id_is_branch = 1'b0; id_pred_taken = 1'b0;
        ex_cdb_flag = 1'b0; ex_cdb_rob_id = 32'd0; ex_cdb_val = 32'd0;
        ex_cdb_jump = 1'b0; ex_cdb_jump_pc = 32'd0;
        ld_cdb_flag = 1'b0; ld_cdb_rob_id = 32'd0; ld_cdb_val = 32'd0;
        rob_id1 = 32'd0; rob_id2 = 32'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic alloc(input logic [4:0] rd, input logic br, input logic pred);
        id_alloc_flag = 1'b1; id_rd = rd; id_is_branch = br; id_pred_taken = pred;
        step();
        id_alloc_flag = 1'b0; id_is_branch = 1'b0; id_pred_taken = 1'b0;
    endtask

    task automatic ex_wb(input logic [31:0] id, input logic [31:0] val,
                         input logic jmp, input logic [31:0] pc);
        ex_cdb_flag = 1'b1; ex_cdb_rob_id = id; ex_cdb_val = val;
        ex_cdb_jump = jmp; ex_cdb_jump_pc = pc;
        step();
        ex_cdb_flag = 1'b0;
    endtask

    task automatic check_commit(input string tag, input logic [4:0] rd,
                                input logic [31:0] id, input logic [31:0] val);
        check_eq({tag, "_flag"}, 32'(ROB_cmt_flag), 32'd1);
        check_eq({tag, "_rd"},   32'(ROB_cmt_rd),   32'(rd));
        check_eq({tag, "_id"},   ROB_cmt_rob_id,    id);
        check_eq({tag, "_val"},  ROB_cmt_val,       val);
    endtask

    initial begin
        rdy = 1'b1;
        rst = 1'b1;
        idle_inputs();
        // Reset state, with an allocation request that reset must override
        id_alloc_flag = 1'b1; id_rd = 5'd3;
        step();
        step();
        rst = 1'b0;
        id_alloc_flag = 1'b0;
        check_eq("rst_full", 32'(rob_full), 32'd0);
        check_eq("rst_next_id", rob_next_id, 32'd1);
        check_eq("rst_cmt_flag", 32'(ROB_cmt_flag), 32'd0);
        check_eq("rst_stall", 32'(jump_wrong_stall), 32'd0);

        // Single alloc, writeback, commit
        alloc(5'd5, 1'b0, 1'b0);
        check_eq("a_next_id", rob_next_id, 32'd2);
        ex_wb(32'd1, 32'h2A, 1'b0, 32'd0);
        check_eq("a_no_early_cmt", 32'(ROB_cmt_flag), 32'd0);
        step();
        check_commit("a_cmt", 5'd5, 32'd1, 32'h2A);
        step();
        check_eq("a_cmt_pulse", 32'(ROB_cmt_flag), 32'd0);

        // Fill to 16, drop the 17th, free one, wrap
        do_reset();
        for (int i = 0; i < 16; i++) alloc(5'(i + 1), 1'b0, 1'b0);
        check_eq("f_full", 32'(rob_full), 32'd1);
        check_eq("f_next_wrap", rob_next_id, 32'd1);
        alloc(5'd9, 1'b0, 1'b0);
        check_eq("f_drop_full", 32'(rob_full), 32'd1);
        check_eq("f_drop_next", rob_next_id, 32'd1);
        ld_cdb_flag = 1'b1; ld_cdb_rob_id = 32'd1; ld_cdb_val = 32'h55;
        step();
        ld_cdb_flag = 1'b0;
        step();
        check_commit("f_cmt", 5'd1, 32'd1, 32'h55);
        check_eq("f_not_full", 32'(rob_full), 32'd0);
        alloc(5'd7, 1'b0, 1'b0);
        check_eq("f_refull", 32'(rob_full), 32'd1);
        check_eq("f_next_after", rob_next_id, 32'd2);

        // Out-of-order writeback, in-order commit
        do_reset();
        alloc(5'd3, 1'b0, 1'b0);
        alloc(5'd4, 1'b0, 1'b0);
        ex_wb(32'd2, 32'h22, 1'b0, 32'd0);
        step();
        check_eq("o_hold", 32'(ROB_cmt_flag), 32'd0);
        ex_wb(32'd1, 32'h11, 1'b0, 32'd0);
        step();
        check_commit("o_cmt1", 5'd3, 32'd1, 32'h11);
        step();
        check_commit("o_cmt2", 5'd4, 32'd2, 32'h22);
        step();
        check_eq("o_idle", 32'(ROB_cmt_flag), 32'd0);

        // Both CDBs in one cycle
        alloc(5'd8, 1'b0, 1'b0);
        alloc(5'd9, 1'b0, 1'b0);
        ex_cdb_flag = 1'b1; ex_cdb_rob_id = 32'd3; ex_cdb_val = 32'hA3;
        ld_cdb_flag = 1'b1; ld_cdb_rob_id = 32'd4; ld_cdb_val = 32'hB4;
        step();
        ex_cdb_flag = 1'b0; ld_cdb_flag = 1'b0;
        step();
        check_commit("d_cmt3", 5'd8, 32'd3, 32'hA3);
        step();
        check_commit("d_cmt4", 5'd9, 32'd4, 32'hB4);

        // Mispredict flush
        do_reset();
        alloc(5'd0, 1'b1, 1'b0);
        alloc(5'd7, 1'b0, 1'b0);
        ex_cdb_flag = 1'b1; ex_cdb_rob_id = 32'd1; ex_cdb_val = 32'h44;
        ex_cdb_jump = 1'b1; ex_cdb_jump_pc = 32'h100;
        ld_cdb_flag = 1'b1; ld_cdb_rob_id = 32'd2; ld_cdb_val = 32'd9;
        step();
        ex_cdb_flag = 1'b0; ld_cdb_flag = 1'b0;
        rob_id1 = 32'd2;
        #1;
        check_eq("m_lk_rdy", 32'(rob_id1_rdy), 32'd1);
        check_eq("m_lk_val", rob_id1_val, 32'd9);
        step();
        check_commit("m_cmt", 5'd0, 32'd1, 32'h44);
        check_eq("m_no_stall_yet", 32'(jump_wrong_stall), 32'd0);
        id_alloc_flag = 1'b1; id_rd = 5'd6;
        step();
        check_eq("m_stall", 32'(jump_wrong_stall), 32'd1);
        check_eq("m_pc", jump_wrong_pc, 32'h100);
        check_eq("m_cmt_off", 32'(ROB_cmt_flag), 32'd0);
        check_eq("m_next_id", rob_next_id, 32'd1);
        check_eq("m_lk_flushed", 32'(rob_id1_rdy), 32'd0);
        step();
        id_alloc_flag = 1'b0;
        check_eq("m_stall_pulse", 32'(jump_wrong_stall), 32'd0);
        check_eq("m_alloc_dropped", rob_next_id, 32'd1);
        check_eq("m_empty_no_cmt", 32'(ROB_cmt_flag), 32'd0);

        // Lookups and rdy freeze
        do_reset();
        alloc(5'd1, 1'b0, 1'b0);
        alloc(5'd2, 1'b0, 1'b0);
        alloc(5'd3, 1'b0, 1'b0);
        ld_cdb_flag = 1'b1; ld_cdb_rob_id = 32'd3; ld_cdb_val = 32'd7;
        step();
        ld_cdb_flag = 1'b0;
        rob_id1 = 32'd3; rob_id2 = 32'd1;
        #1;
        check_eq("l_id1_rdy", 32'(rob_id1_rdy), 32'd1);
        check_eq("l_id1_val", rob_id1_val, 32'd7);
        check_eq("l_id2_notready", 32'(rob_id2_rdy), 32'd0);
        rob_id2 = 32'd0;
        #1;
        check_eq("l_id0", 32'(rob_id2_rdy), 32'd0);
        rob_id2 = 32'd17;
        #1;
        check_eq("l_id_oor", 32'(rob_id2_rdy), 32'd0);
        ex_wb(32'd1, 32'h33, 1'b0, 32'd0);
        rdy = 1'b0;
        id_alloc_flag = 1'b1; id_rd = 5'd4;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("z_no_cmt", 32'(ROB_cmt_flag), 32'd0);
            check_eq("z_next_frozen", rob_next_id, 32'd4);
        end
        id_alloc_flag = 1'b0;
        rdy = 1'b1;
        step();
        check_commit("z_cmt", 5'd1, 32'd1, 32'h33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
